// File: rtl/touch_arbiter_pkg.sv
// Shared types for the touch arbiter: bout FSM states, winner encoding, score helper.
package touch_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    LOCKOUT,
    SCORE,
    DISPLAY,
    OVER
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  localparam int unsigned FRAME_CNT_W = 8;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] max);
    return (v >= max) ? max : v + 4'd1;
  endfunction

endpackage

// File: rtl/touch_arbiter_frame_counter.sv
// Frame-tick counter shared by the lockout and hold windows; done fires on the tick
// that brings the count up to cmp_i, so the caller can change state on that same edge.
module frame_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         tick_i,
  input  logic [W-1:0] cmp_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = tick_i && !clear_i && (cnt_q == cmp_i - W'(1));

endmodule

// File: rtl/touch_arbiter.sv
// Bout controller: lockout window, touch lights, scoring and winner.
// Optional right-of-way arbitration on double touches via TOUCH_ARBITER_ROW_EN.
//   IDLE    | waiting for start, detectors off
//   ARMED   | detectors on, waiting for first hit
//   LOCKOUT | counting frames while the opponent may still land a hit
//   SCORE   | one cycle: award points, pulse touch
//   DISPLAY | lights held for the hold period
//   OVER    | bout finished, scores frozen
module touch_arbiter
  import touch_arbiter_pkg::*;
#(
  parameter int unsigned LOCKOUT_FRAMES = 3,
  parameter int unsigned HOLD_FRAMES    = 60,
  parameter int unsigned WIN_SCORE      = 5
) (
  input  logic       clk_pixel_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic       frame_tick_in,
  input  logic       p1_attacking_in,
  input  logic       p2_attacking_in,
  input  logic       p1_hit_in,
  input  logic       p2_hit_in,
  output logic       detect_en_out,
  output logic       p1_light_out,
  output logic       p2_light_out,
  output logic       touch_pulse_out,
  output logic [3:0] p1_score_out,
  output logic [3:0] p2_score_out,
  output logic       bout_over_out,
  output logic [1:0] winner_out
);

  localparam logic [FRAME_CNT_W-1:0] LOCK_CMP = FRAME_CNT_W'(LOCKOUT_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] HOLD_CMP = FRAME_CNT_W'(HOLD_FRAMES);
  localparam logic [3:0]             WIN      = 4'(WIN_SCORE);

  state_t     state_q, state_d;
  logic       p1_hit_q, p2_hit_q;
  logic       p1_edge, p2_edge;
  logic       p1_light_q, p1_light_d, p2_light_q, p2_light_d;
  logic [3:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
  logic       bout_over_q, bout_over_d;
  winner_t    winner_q, winner_d;
  logic       detect_en, touch_pulse;
  logic       p1_award, p2_award;
  logic       cnt_clear, cnt_done;
  logic [FRAME_CNT_W-1:0] cnt_cmp;

  assign p1_edge = p1_hit_in && !p1_hit_q;
  assign p2_edge = p2_hit_in && !p2_hit_q;

`ifdef TOUCH_ARBITER_ROW_EN
  logic    p1_att_q, p2_att_q, p1_att_edge, p2_att_edge;
  logic    row_set_q, row_set_d;
  winner_t row_prio_q, row_prio_d;

  assign p1_att_edge = p1_attacking_in && !p1_att_q;
  assign p2_att_edge = p2_attacking_in && !p2_att_q;

  // Only the first attack edge seen while armed decides priority; a tie leaves none.
  always_comb begin
    row_set_d  = row_set_q;
    row_prio_d = row_prio_q;
    if (state_d == ARMED && state_q != ARMED) begin
      row_set_d  = 1'b0;
      row_prio_d = WIN_NONE;
    end else if (state_q == ARMED && !row_set_q && (p1_att_edge || p2_att_edge)) begin
      row_set_d  = 1'b1;
      row_prio_d = (p1_att_edge && p2_att_edge) ? WIN_NONE :
                   (p1_att_edge ? WIN_P1 : WIN_P2);
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      p1_att_q   <= 1'b0;
      p2_att_q   <= 1'b0;
      row_set_q  <= 1'b0;
      row_prio_q <= WIN_NONE;
    end else begin
      p1_att_q   <= p1_attacking_in;
      p2_att_q   <= p2_attacking_in;
      row_set_q  <= row_set_d;
      row_prio_q <= row_prio_d;
    end
  end
`else
  logic unused_attacking;
  assign unused_attacking = p1_attacking_in | p2_attacking_in;
`endif

  always_comb begin
    state_d     = state_q;
    p1_light_d  = p1_light_q;
    p2_light_d  = p2_light_q;
    p1_score_d  = p1_score_q;
    p2_score_d  = p2_score_q;
    bout_over_d = bout_over_q;
    winner_d    = winner_q;
    detect_en   = 1'b0;
    touch_pulse = 1'b0;
    cnt_clear   = 1'b1;
    cnt_cmp     = LOCK_CMP;
    p1_award    = p1_light_q;
    p2_award    = p2_light_q;
`ifdef TOUCH_ARBITER_ROW_EN
    if (p1_light_q && p2_light_q) begin
      p1_award = (row_prio_q == WIN_P1);
      p2_award = (row_prio_q == WIN_P2);
    end
`endif

    case (state_q)
      IDLE, OVER: begin
        if (start_in) begin
          state_d     = ARMED;
          p1_score_d  = 4'd0;
          p2_score_d  = 4'd0;
          bout_over_d = 1'b0;
          winner_d    = WIN_NONE;
        end
      end
      ARMED: begin
        detect_en = 1'b1;
        if (p1_edge || p2_edge) begin
          state_d    = LOCKOUT;
          p1_light_d = p1_edge;
          p2_light_d = p2_edge;
        end
      end
      LOCKOUT: begin
        detect_en = 1'b1;
        cnt_clear = 1'b0;
        if (p1_edge) p1_light_d = 1'b1;
        if (p2_edge) p2_light_d = 1'b1;
        if (cnt_done) state_d = SCORE;
      end
      SCORE: begin
        touch_pulse = 1'b1;
        if (p1_award) p1_score_d = sat_inc(p1_score_q, WIN);
        if (p2_award) p2_score_d = sat_inc(p2_score_q, WIN);
        state_d = DISPLAY;
      end
      DISPLAY: begin
        cnt_clear = 1'b0;
        cnt_cmp   = HOLD_CMP;
        if (cnt_done) begin
          p1_light_d = 1'b0;
          p2_light_d = 1'b0;
          if (p1_score_q == WIN || p2_score_q == WIN) begin
            state_d     = OVER;
            bout_over_d = 1'b1;
            winner_d    = (p1_score_q == WIN && p2_score_q == WIN) ? WIN_DRAW :
                          ((p1_score_q == WIN) ? WIN_P1 : WIN_P2);
          end else begin
            state_d = ARMED;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      p1_hit_q    <= 1'b0;
      p2_hit_q    <= 1'b0;
      p1_light_q  <= 1'b0;
      p2_light_q  <= 1'b0;
      p1_score_q  <= 4'd0;
      p2_score_q  <= 4'd0;
      bout_over_q <= 1'b0;
      winner_q    <= WIN_NONE;
    end else begin
      state_q     <= state_d;
      p1_hit_q    <= p1_hit_in;
      p2_hit_q    <= p2_hit_in;
      p1_light_q  <= p1_light_d;
      p2_light_q  <= p2_light_d;
      p1_score_q  <= p1_score_d;
      p2_score_q  <= p2_score_d;
      bout_over_q <= bout_over_d;
      winner_q    <= winner_d;
    end
  end

  frame_counter #(.W(FRAME_CNT_W)) u_frame_counter (
    .clk_i   (clk_pixel_in),
    .rst_i   (rst_in),
    .clear_i (cnt_clear),
    .tick_i  (frame_tick_in),
    .cmp_i   (cnt_cmp),
    .done_o  (cnt_done)
  );

  assign detect_en_out   = detect_en;
  assign touch_pulse_out = touch_pulse;
  assign p1_light_out    = p1_light_q;
  assign p2_light_out    = p2_light_q;
  assign p1_score_out    = p1_score_q;
  assign p2_score_out    = p2_score_q;
  assign bout_over_out   = bout_over_q;
  assign winner_out      = winner_q;

endmodule

// File: tb/tb_touch_arbiter.sv
// Self-checking bench for touch_arbiter: randomized touches scored against a
// touch-level model (who lit, points, winner) rather than a cycle model.
module tb_touch_arbiter;

  localparam int LOCK = 3;
  localparam int HOLD = 60;
  localparam int WIN  = 5;

  logic       clk_pixel_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       start_in = 1'b0;
  logic       frame_tick_in = 1'b0;
  logic       p1_attacking_in = 1'b0;
  logic       p2_attacking_in = 1'b0;
  logic       p1_hit_in = 1'b0;
  logic       p2_hit_in = 1'b0;
  logic       detect_en_out, p1_light_out, p2_light_out, touch_pulse_out;
  logic [3:0] p1_score_out, p2_score_out;
  logic       bout_over_out;
  logic [1:0] winner_out;

  int         n_checks = 0;
  int         n_fail = 0;
  int         m1, m2;
  bit         m_over;
  logic [1:0] m_win;

  touch_arbiter #(.LOCKOUT_FRAMES(LOCK), .HOLD_FRAMES(HOLD), .WIN_SCORE(WIN)) dut (
    .clk_pixel_in    (clk_pixel_in),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .frame_tick_in   (frame_tick_in),
    .p1_attacking_in (p1_attacking_in),
    .p2_attacking_in (p2_attacking_in),
    .p1_hit_in       (p1_hit_in),
    .p2_hit_in       (p2_hit_in),
    .detect_en_out   (detect_en_out),
    .p1_light_out    (p1_light_out),
    .p2_light_out    (p2_light_out),
    .touch_pulse_out (touch_pulse_out),
    .p1_score_out    (p1_score_out),
    .p2_score_out    (p2_score_out),
    .bout_over_out   (bout_over_out),
    .winner_out      (winner_out)
  );

  always #5 clk_pixel_in = ~clk_pixel_in;

  task automatic cyc();
    @(posedge clk_pixel_in);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (2) cyc();
    n_checks++;
    if ({detect_en_out, p1_light_out, p2_light_out, touch_pulse_out, p1_score_out,
         p2_score_out, bout_over_out, winner_out} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got det=%0b l=%0b%0b tp=%0b s=%0d/%0d over=%0b win=%0d expected all 0",
               detect_en_out, p1_light_out, p2_light_out, touch_pulse_out, p1_score_out,
               p2_score_out, bout_over_out, winner_out);
    end
    rst_in = 1'b0;
    repeat (4) cyc();
    n_checks++;
    if (detect_en_out !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start: detect_en_out=%0b expected 0", detect_en_out);
    end
  endtask

  task automatic do_start();
    start_in = 1'b1;
    cyc();
    start_in = 1'b0;
    m1 = 0; m2 = 0; m_over = 1'b0; m_win = 2'b00;
    n_checks++;
    if ({detect_en_out, p1_score_out, p2_score_out, bout_over_out, winner_out} !== 12'b1_0000_0000_0_00) begin
      n_fail++;
      $display("FAIL start: got det=%0b s=%0d/%0d over=%0b win=%0d expected det=1 s=0/0 over=0 win=0",
               detect_en_out, p1_score_out, p2_score_out, bout_over_out, winner_out);
    end
  endtask

  // first: 1=p1, 2=p2, 3=both in one cycle. k: opponent hits after k frame ticks (-1 none).
  // att: 0 none, 1 p1 attacks first, 2 p2 first, 3 same cycle.
  task automatic run_touch(input int first, input int k, input int att, input bit hold_p1);
    int sec, lt, ht, pulses, lt_at_pulse, ht_at_drop;
    bit lit1, lit2, inc1, inc2, l1p, l2p, sec_raised, released, dropped, score_cycle, tick;
    sec = 0;
    if (k >= 0 && first == 1) sec = 2;
    else if (k >= 0 && first == 2) sec = 1;
    lit1 = ((first & 1) != 0) || (sec == 1 && k < LOCK);
    lit2 = ((first & 2) != 0) || (sec == 2 && k < LOCK);
    inc1 = lit1;
    inc2 = lit2;
`ifdef TOUCH_ARBITER_ROW_EN
    if (lit1 && lit2) begin
      inc1 = (att == 1);
      inc2 = (att == 2);
    end
`endif
    if (inc1 && m1 < WIN) m1++;
    if (inc2 && m2 < WIN) m2++;
    m_over = (m1 == WIN) || (m2 == WIN);
    m_win  = m_over ? {m2 == WIN, m1 == WIN} : 2'b00;

    n_checks++;
    if (detect_en_out !== 1'b1) begin
      n_fail++;
      $display("FAIL armed_before_touch: detect_en_out=%0b expected 1", detect_en_out);
    end
    case (att)
      1: begin p1_attacking_in = 1'b1; cyc(); p2_attacking_in = 1'b1; cyc(); end
      2: begin p2_attacking_in = 1'b1; cyc(); p1_attacking_in = 1'b1; cyc(); end
      3: begin p1_attacking_in = 1'b1; p2_attacking_in = 1'b1; cyc(); end
      default: cyc();
    endcase

    p1_hit_in = ((first & 1) != 0);
    p2_hit_in = ((first & 2) != 0);
    frame_tick_in = 1'($urandom_range(0, 1));
    cyc();
    frame_tick_in = 1'b0;
    n_checks++;
    if ({p1_light_out, p2_light_out} !== {p1_hit_in, p2_hit_in}) begin
      n_fail++;
      $display("FAIL first_light: got %0b%0b expected %0b%0b", p1_light_out, p2_light_out,
               p1_hit_in, p2_hit_in);
    end

    lt = 0; ht = 0; pulses = 0; lt_at_pulse = -1; ht_at_drop = -1;
    l1p = 1'b0; l2p = 1'b0; sec_raised = 1'b0; released = 1'b0; dropped = 1'b0; score_cycle = 1'b0;
    for (int c = 0; c < 3000 && !dropped; c++) begin
      tick = 1'($urandom_range(0, 1));
      if (score_cycle) tick = 1'b0;
      if (sec != 0 && !sec_raised && lt == k) begin
        tick = 1'b0;
        if (sec == 1) p1_hit_in = 1'b1; else p2_hit_in = 1'b1;
        sec_raised = 1'b1;
      end
      if (pulses > 0 && ht >= 10 && !released) begin
        if (!hold_p1) p1_hit_in = 1'b0;
        p2_hit_in = 1'b0;
        p1_attacking_in = 1'b0;
        p2_attacking_in = 1'b0;
        released = 1'b1;
      end
      frame_tick_in = tick;
      cyc();
      frame_tick_in = 1'b0;
      score_cycle = 1'b0;
      if (tick) begin
        lt++;
        if (pulses > 0) ht++;
      end
      if (touch_pulse_out) begin
        pulses++;
        lt_at_pulse = lt;
        l1p = p1_light_out;
        l2p = p2_light_out;
        score_cycle = 1'b1;
      end
      if (pulses > 0 && !p1_light_out && !p2_light_out) begin
        dropped = 1'b1;
        ht_at_drop = ht;
      end
    end

    n_checks++;
    if (!dropped) begin
      n_fail++;
      $display("FAIL touch_timeout: lights never cleared, pulses=%0d expected 1", pulses);
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL touch_pulse_count: got %0d expected 1", pulses);
    end
    n_checks++;
    if (lt_at_pulse != LOCK) begin
      n_fail++;
      $display("FAIL lockout_ticks: pulse after %0d ticks expected %0d", lt_at_pulse, LOCK);
    end
    n_checks++;
    if ({l1p, l2p} !== {lit1, lit2}) begin
      n_fail++;
      $display("FAIL lights_at_score: got %0b%0b expected %0b%0b (first=%0d k=%0d)",
               l1p, l2p, lit1, lit2, first, k);
    end
    n_checks++;
    if (ht_at_drop != HOLD) begin
      n_fail++;
      $display("FAIL hold_ticks: lights cleared after %0d ticks expected %0d", ht_at_drop, HOLD);
    end
    n_checks++;
    if (p1_score_out !== 4'(m1) || p2_score_out !== 4'(m2)) begin
      n_fail++;
      $display("FAIL scores: got %0d/%0d expected %0d/%0d (first=%0d k=%0d att=%0d)",
               p1_score_out, p2_score_out, m1, m2, first, k, att);
    end
    n_checks++;
    if ({bout_over_out, winner_out, detect_en_out} !== {m_over, m_win, !m_over}) begin
      n_fail++;
      $display("FAIL bout_state: got over=%0b win=%0d det=%0b expected over=%0b win=%0d det=%0b",
               bout_over_out, winner_out, detect_en_out, m_over, m_win, !m_over);
    end
  endtask

  task automatic test_single();
    do_start();
    run_touch(1, -1, 0, 1'b0);
  endtask

  task automatic test_double();
    run_touch(1, 2, 0, 1'b0);
  endtask

  task automatic test_late();
    run_touch(1, 4, 0, 1'b0);
  endtask

  task automatic test_hold_high();
    bit bad;
    run_touch(1, -1, 0, 1'b1);
    bad = 1'b0;
    for (int c = 0; c < 30; c++) begin
      frame_tick_in = 1'($urandom_range(0, 1));
      cyc();
      if (touch_pulse_out || p1_light_out || p2_light_out || !detect_en_out) bad = 1'b1;
    end
    frame_tick_in = 1'b0;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL held_hit_retrigger: held p1 hit caused activity, got 1 expected 0");
    end
    p1_hit_in = 1'b0;
    cyc();
    while (!m_over) run_touch(1, -1, 0, 1'b0);
  endtask

  task automatic test_draw();
    do_start();
`ifdef TOUCH_ARBITER_ROW_EN
    run_touch(3, -1, 2, 1'b0);
    run_touch(3, -1, 3, 1'b0);
    run_touch(2, 1, 1, 1'b0);
    while (!m_over) run_touch(2, -1, 0, 1'b0);
`else
    repeat (5) run_touch(3, -1, 0, 1'b0);
    n_checks++;
    if (winner_out !== 2'b11) begin
      n_fail++;
      $display("FAIL draw_winner: got %0d expected 3", winner_out);
    end
`endif
    do_start();
  endtask

  task automatic test_random();
    int t, f, k, a;
    for (int b = 0; b < 2; b++) begin
      t = 0;
      while (!m_over && t < 60) begin
        f = int'($urandom_range(1, 3));
        k = int'($urandom_range(0, 6));
        if (k == 6) k = -1;
        a = int'($urandom_range(0, 3));
        if (t > 30) begin f = 1; k = -1; end
        run_touch(f, k, a, 1'b0);
        t++;
      end
      do_start();
    end
  endtask

  task automatic test_reset_mid();
    bit seen, bad;
    p1_hit_in = 1'b1;
    cyc();
    p1_hit_in = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      frame_tick_in = 1'(c % 2);
      cyc();
      if (touch_pulse_out) seen = 1'b1;
    end
    frame_tick_in = 1'b0;
    repeat (3) cyc();
    n_checks++;
    if (!seen || p1_light_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reach_display: pulse_seen=%0b light=%0b expected 1 1", seen, p1_light_out);
    end
    rst_in = 1'b1;
    cyc();
    rst_in = 1'b0;
    n_checks++;
    if ({detect_en_out, p1_light_out, p2_light_out, touch_pulse_out, p1_score_out,
         p2_score_out, bout_over_out, winner_out} !== 15'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got det=%0b l=%0b%0b s=%0d/%0d over=%0b win=%0d expected all 0",
               detect_en_out, p1_light_out, p2_light_out, p1_score_out, p2_score_out,
               bout_over_out, winner_out);
    end
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      frame_tick_in = 1'($urandom_range(0, 1));
      p2_hit_in = (c == 4);
      cyc();
      if (detect_en_out || p1_light_out || p2_light_out || touch_pulse_out) bad = 1'b1;
    end
    frame_tick_in = 1'b0;
    p2_hit_in = 1'b0;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL idle_after_reset: activity without start, got 1 expected 0");
    end
    do_start();
    run_touch(2, -1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_double();
    test_late();
    test_hold_high();
    test_draw();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/touch_arbiter.md
Name: touch_arbiter

Overview:
- Bout controller that sits downstream of the two per-player saber collision detectors and turns their raw hit flags into scored touches.
- Enforces a fencing-style lockout window so that near-simultaneous hits count as a double touch. Holds the touch lights for a display period, keeps score, and declares the bout winner.
- Drives the enable that gates both collision detectors.

Parameters:
- LOCKOUT_FRAMES, 3, frame ticks after the first hit during which the opponent's hit still counts (1..255)
- HOLD_FRAMES, 60, frame ticks that lights stay on before re-arming (1..255)
- WIN_SCORE, 5, points needed to win (1..15)

Ports:
- clk_pixel_in  in  1  pixel clock; the only clock
- rst_in  in  1  synchronous, active-high reset
- start_in  in  1  one-cycle pulse that starts a new bout
- frame_tick_in  in  1  one-cycle pulse, once per video frame
- p1_attacking_in  in  1  player 1 is in an attack motion
- p2_attacking_in  in  1  player 2 is in an attack motion
- p1_hit_in  in  1  player 1's saber is colliding with player 2 (detector output)
- p2_hit_in  in  1  player 2's saber is colliding with player 1
- detect_en_out  out  1  enables both collision detectors
- p1_light_out  out  1  player 1 touch light
- p2_light_out  out  1  player 2 touch light
- touch_pulse_out  out  1  one-cycle pulse when a touch is scored
- p1_score_out  out  4  player 1 score
- p2_score_out  out  4  player 2 score
- bout_over_out  out  1  bout finished
- winner_out  out  2  00 none, 01 player 1, 10 player 2, 11 draw

Behaviour:
- Single clock (clk_pixel_in); reset is synchronous and active-high (rst_in). After reset:
  - state is IDLE
  - all outputs are 0
  - counters and hit-edge registers are cleared
- A reset asserted mid-operation takes effect at the next edge, whatever the state.
- Hit detection: a hit is the rising edge of p*_hit_in. Each input is registered once and a hit is detected when the current value is 1 and the registered value is 0. A hit held high across states never re-triggers.
- IDLE: detect_en_out = 0. start_in moves to ARMED and clears scores, winner_out and bout_over_out.
- ARMED: detect_en_out = 1.
  - Any hit edge in cycle N moves to LOCKOUT in N+1, with the corresponding light(s) set in N+1.
  - Both edges in the same cycle set both lights.
  - The lockout counter loads 0.
- LOCKOUT: detect_en_out = 1.
  - A hit edge from the player whose light is still off sets that light next cycle.
  - A repeat hit from an already-lit player is ignored.
  - Each frame_tick_in increments the counter.
  - When the counter reaches LOCKOUT_FRAMES, move to SCORE in the same cycle the counter registers that value.
- SCORE, one cycle: detect_en_out = 0.
  - Add 1 to the score of each lit player, saturating at WIN_SCORE.
  - touch_pulse_out = 1 for this cycle only.
  - Then go to DISPLAY with the hold counter set to 0.
- DISPLAY: detect_en_out = 0; lights stay held.
  - Count frame_tick_in up to HOLD_FRAMES, then clear the lights.
  - If either score equals WIN_SCORE, go to OVER; otherwise go to ARMED.
- OVER: bout_over_out = 1.
  - winner_out = 01 or 10 for a single winner; 11 if both reached WIN_SCORE on the same double touch.
  - Scores are frozen. start_in behaves as in IDLE.
- start_in is ignored in ARMED, LOCKOUT, SCORE and DISPLAY.
- frame_tick_in coinciding with a hit edge in ARMED: the tick is not counted.
- p*_attacking_in is used only by the optional feature.

Optional Feature:
- Macro TOUCH_ARBITER_ROW_EN enables right-of-way arbitration.
- With the macro defined:
  - In ARMED, track which player raised attacking first. Record the first rising edge; if both edges fall in the same cycle, there is no priority. Clear the record on entry to ARMED.
  - On a double touch, only the priority player scores. If there is no priority, neither player scores and touch_pulse_out still pulses.
  - Both lights still show.
- Without the macro: a double touch scores both players, and the attacking inputs are unused.

Decomposition:
- Package touch_arbiter_pkg holds:
  - the state enum (IDLE, ARMED, LOCKOUT, SCORE, DISPLAY, OVER)
  - the winner_t encoding constants (WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW)
- One sub-module, frame_counter: counts frame ticks with a clear input and a done flag against a compare value. Instantiate it twice, once for lockout and once for hold, or share one instance between the two states.

Test Plan:
- Reset, start_in, then p1_hit_in rises with no p2 hit (LOCKOUT_FRAMES=3, HOLD_FRAMES=60) -> p1_light_out=1 next cycle; touch_pulse_out after the 3rd frame tick; p1_score_out=1, p2_score_out=0; lights clear after 60 ticks; detect_en_out returns to 1.
- p1 hit, then p2 hit after 2 ticks -> both lights on; both scores become 1.
- p1 hit, then p2 hit after 4 ticks -> only p1 scores; p2's edge falls in DISPLAY and is ignored.
- Both scores at 4 with WIN_SCORE=5, then a double touch -> both scores 5; bout_over_out=1; winner_out=11. A following start_in clears scores to 0 and returns to ARMED.
- Hold p1_hit_in high from ARMED through DISPLAY and back to ARMED -> exactly one touch is scored. With TOUCH_ARBITER_ROW_EN, p2 attacks first and a double touch occurs -> only p2 scores.
- Assert rst_in during DISPLAY -> next cycle all outputs are 0 and state is IDLE; start_in is required to re-arm.
